// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if -- pixel timing bundle from the sync generator to its consumers.
//   p_tick     : one-clk pixel enable
//   x, y       : current pixel coordinates (10-bit)
//   video_on   : current coordinate lies in the visible area
//   hsync      : horizontal sync, active-low
//   vsync      : vertical sync, active-low
//   frame_tick : one-clk pulse at the start of vertical retrace
// master = the timing generator, slave = graphics logic that consumes it.
interface vga_sync_gen_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (
    output p_tick, x, y, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- 640x480@60 Hz timing source.
// Divides clk down to a pixel enable and runs the horizontal/vertical
// counters; produces coordinates, video_on, active-low sync pins and a
// once-per-frame tick. All outputs are registered.
//   clk   : system clock
//   reset : synchronous reset, active-low
//   vga   : vga_sync_gen_if.master (p_tick, x, y, video_on, hsync, vsync, frame_tick)
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_LINE = 481
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] TICK_Y   = 10'(TICK_LINE);

  logic [DIV_W-1:0] div_reg, div_next;
  logic             p_tick_reg, p_tick_next;
  logic [9:0]       x_reg, x_next;
  logic [9:0]       y_reg, y_next;
  logic             video_on_reg, video_on_next;
  logic             hsync_reg, hsync_next;
  logic             vsync_reg, vsync_next;
  logic             frame_tick_reg, frame_tick_next;

  always_comb begin
    div_next        = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
    // p_tick is registered alongside div so it is high while div==CLK_DIV-1.
    p_tick_next     = (div_next == DIV_LAST);

    x_next          = x_reg;
    y_next          = y_reg;
    if (p_tick_reg) begin
      if (x_reg == H_LAST) begin
        x_next = '0;
        y_next = (y_reg == V_LAST) ? '0 : y_reg + 10'd1;
      end else begin
        x_next = x_reg + 10'd1;
      end
    end

    // Decoded from the next coordinates so the registered sync/video
    // outputs line up with the registered x/y with no skew.
    video_on_next   = (x_next < H_VIS) && (y_next < V_VIS);
    hsync_next      = !((x_next >= HS_START) && (x_next <= HS_END));
    vsync_next      = !((y_next >= VS_START) && (y_next <= VS_END));
    // Only an actual pixel step can land on (0,TICK_LINE), so the pulse is
    // one clk wide whatever CLK_DIV is.
    frame_tick_next = p_tick_reg && (x_next == '0) && (y_next == TICK_Y);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_reg        <= '0;
      p_tick_reg     <= 1'b0;
      x_reg          <= '0;
      y_reg          <= '0;
      video_on_reg   <= 1'b1;
      hsync_reg      <= 1'b1;
      vsync_reg      <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      div_reg        <= div_next;
      p_tick_reg     <= p_tick_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      video_on_reg   <= video_on_next;
      hsync_reg      <= hsync_next;
      vsync_reg      <= vsync_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign vga.p_tick     = p_tick_reg;
  assign vga.x          = x_reg;
  assign vga.y          = y_reg;
  assign vga.video_on   = video_on_reg;
  assign vga.hsync      = hsync_reg;
  assign vga.vsync      = vsync_reg;
  assign vga.frame_tick = frame_tick_reg;

endmodule
